// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined adder/subtractor/comparator with a carry chain split
// into STAGES chunks. Each stage resolves one chunk and hands its carry to the
// next. A single global stall (advance) freezes the whole pipe whenever the
// output holds an undelivered beat.
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       alufn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             z_out,
  output logic             v_out,
  output logic             n_out
);

  localparam int CW = WIDTH / STAGES;
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_CMPEQ = 2'b10;
  localparam logic [1:0] OP_CMPLT = 2'b11;

  // Adds chunk k of the operands plus carry-in and splices it into the
  // partial sum; returns {carry_out, updated_partial_sum}.
  function automatic logic [WIDTH:0] chunk_add(input logic [WIDTH-1:0] op_a,
                                               input logic [WIDTH-1:0] op_bp,
                                               input logic [WIDTH-1:0] part_s,
                                               input logic             cin,
                                               input int               k);
    logic [CW:0]      sum;
    logic [WIDTH-1:0] s_new;
    sum = {1'b0, op_a[k*CW +: CW]} + {1'b0, op_bp[k*CW +: CW]} + {{CW{1'b0}}, cin};
    s_new = part_s;
    s_new[k*CW +: CW] = sum[CW-1:0];
    return {sum[CW], s_new};
  endfunction

  // Compares report a boolean in bit 0; arithmetic ops report the sum.
  function automatic logic [WIDTH-1:0] select_result(input logic [1:0]       op,
                                                     input logic [WIDTH-1:0] s,
                                                     input logic             z,
                                                     input logic             lt);
    case (op)
      OP_CMPEQ: return {{(WIDTH-1){1'b0}}, z};
      OP_CMPLT: return {{(WIDTH-1){1'b0}}, lt};
      default:  return s;
    endcase
  endfunction

  // Per-stage state: the full operands ride along so later stages can pick
  // their chunk; s holds the chunks finished so far.
  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] bp_q  [STAGES];
  logic [WIDTH-1:0] bp_d  [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic [1:0]       op_q  [STAGES];
  logic [1:0]       op_d  [STAGES];

  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d;
  logic             v_q, v_d;
  logic             n_q, n_d;

  logic             advance;
  logic [WIDTH-1:0] src_a, src_bp, src_s;
  logic             src_c, src_vld;
  logic [1:0]       src_op;
  logic [WIDTH:0]   add_r;
  int               pk;

  assign advance   = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign result    = res_q;
  assign cout      = c_q[STAGES-1];
  assign z_out     = z_q;
  assign v_out     = v_q;
  assign n_out     = n_q;

  // Next-state for every stage: hold on stall, otherwise shift one stage and
  // resolve that stage's chunk; the last stage also forms flags and result.
  always_comb begin
    src_a   = '0;
    src_bp  = '0;
    src_s   = '0;
    src_c   = 1'b0;
    src_vld = 1'b0;
    src_op  = OP_ADD;
    add_r   = '0;
    pk      = 0;
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = vld_q[k];
      c_d[k]   = c_q[k];
      a_d[k]   = a_q[k];
      bp_d[k]  = bp_q[k];
      s_d[k]   = s_q[k];
      op_d[k]  = op_q[k];
    end
    res_d = res_q;
    z_d   = z_q;
    v_d   = v_q;
    n_d   = n_q;
    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        pk = (k == 0) ? 0 : k - 1;
        if (k == 0) begin
          src_vld = in_valid;
          src_a   = a;
          src_bp  = (alufn == OP_ADD) ? b : ~b;
          src_c   = (alufn != OP_ADD);
          src_s   = '0;
          src_op  = alufn;
        end else begin
          src_vld = vld_q[pk];
          src_a   = a_q[pk];
          src_bp  = bp_q[pk];
          src_c   = c_q[pk];
          src_s   = s_q[pk];
          src_op  = op_q[pk];
        end
        add_r    = chunk_add(src_a, src_bp, src_s, src_c, k);
        vld_d[k] = src_vld;
        a_d[k]   = src_a;
        bp_d[k]  = src_bp;
        s_d[k]   = add_r[WIDTH-1:0];
        c_d[k]   = add_r[WIDTH];
        op_d[k]  = src_op;
      end
      z_d   = (s_d[STAGES-1] == '0);
      n_d   = s_d[STAGES-1][WIDTH-1];
      v_d   = (a_d[STAGES-1][WIDTH-1] == bp_d[STAGES-1][WIDTH-1]) &&
              (s_d[STAGES-1][WIDTH-1] != a_d[STAGES-1][WIDTH-1]);
      res_d = select_result(op_d[STAGES-1], s_d[STAGES-1], z_d, n_d ^ v_d);
    end
  end

  // Control and visible outputs: cleared asynchronously so reset drops
  // every in-flight beat and presents an all-zero result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        c_q[k]   <= 1'b0;
      end
      res_q <= '0;
      z_q   <= 1'b0;
      v_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        c_q[k]   <= c_d[k];
      end
      res_q <= res_d;
      z_q   <= z_d;
      v_q   <= v_d;
      n_q   <= n_d;
    end
  end

  // Datapath payload: qualified by the stage valids, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      a_q[k]  <= a_d[k];
      bp_q[k] <= bp_d[k];
      s_q[k]  <= s_d[k];
      op_q[k] <= op_d[k];
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: scoreboard bench for addsub_pipe (WIDTH=16). Expected
// results come from an independent reference model and are queued at accept.
module tb_addsub_pipe #(
  parameter int STAGES = 4
);

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        v;
    logic        n;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  alufn;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        z_out;
  logic        v_out;
  logic        n_out;

  int   checks = 0;
  int   errors = 0;
  out_t sb[$];

  addsub_pipe #(.WIDTH(16), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alufn     (alufn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .z_out     (z_out),
    .v_out     (v_out),
    .n_out     (n_out)
  );

  always #5 clk = ~clk;

  // Reference model: full-width add with signed compare taken from $signed.
  function automatic out_t model(input logic [15:0] ma, input logic [15:0] mb, input logic [1:0] op);
    out_t        o;
    logic [15:0] bp;
    logic [16:0] full;
    bp   = (op == 2'b00) ? mb : ~mb;
    full = {1'b0, ma} + {1'b0, bp} + {16'h0000, (op != 2'b00)};
    o.c  = full[16];
    o.z  = (full[15:0] == 16'h0000);
    o.n  = full[15];
    o.v  = (ma[15] == bp[15]) && (full[15] != ma[15]);
    case (op)
      2'b10:   o.res = {15'h0000, (ma == mb)};
      2'b11:   o.res = {15'h0000, ($signed(ma) < $signed(mb))};
      default: o.res = full[15:0];
    endcase
    return o;
  endfunction

  function automatic logic [15:0] pick();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return r[15:0];
    endcase
  endfunction

  // One clock cycle: drive at negedge, observe handshake/outputs, push the
  // expected result for an accepted beat, then wait for the active edge.
  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic [1:0] op, input logic ordy,
                      output logic acc, output logic dlv, output logic rdy,
                      output logic ov, output out_t obs);
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    alufn     = op;
    out_ready = ordy;
    #1;
    rdy = in_ready;
    ov  = out_valid;
    acc = iv && in_ready;
    dlv = out_valid && ordy;
    obs = {result, cout, z_out, v_out, n_out};
    if (acc) sb.push_back(model(ia, ib, op));
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; alufn = 2'b00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
    checks++;
    if ({cout, z_out, v_out, n_out} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {cout, z_out, v_out, n_out});
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic [1:0]  vo [6];
    out_t        ev [6];
    logic        acc, dlv, rdy, ov, got;
    out_t        obs, junk;
    int          lat;
    va = '{16'hFFFF, 16'h0101, 16'h8000, 16'hC0FF, 16'hA234, 16'hA234};
    vb = '{16'h0001, 16'h0011, 16'h0001, 16'hEECC, 16'hA234, 16'h8000};
    vo = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10};
    ev = '{{16'h0000, 4'b1100}, {16'h00F0, 4'b1000}, {16'h7FFF, 4'b1010},
           {16'h0001, 4'b0001}, {16'h0001, 4'b1100}, {16'h0000, 4'b1000}};
    for (int t = 0; t < 6; t++) begin
      step(1'b1, va[t], vb[t], vo[t], 1'b1, acc, dlv, rdy, ov, obs);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL vec%0d_accept got %b want 1", t, acc); end
      got = 1'b0;
      lat = 0;
      for (int c = 1; c <= 3 * STAGES + 4 && !got; c++) begin
        step(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, acc, dlv, rdy, ov, obs);
        if (dlv) begin
          got = 1'b1;
          lat = c;
          if (sb.size() > 0) junk = sb.pop_front();
          checks++;
          if (obs !== ev[t]) begin errors++; $display("FAIL vec%0d_value got %h want %h", t, obs, ev[t]); end
        end
      end
      checks++;
      if (!got || lat != STAGES) begin
        errors++; $display("FAIL vec%0d_latency got %0d want %0d (delivered=%b)", t, lat, STAGES, got);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, dlv, rdy, ov, stall;
    out_t obs, ex;
    int   sent, got;
    sent = 0;
    got  = 0;
    for (int i = 0; i < STAGES + 40 && (sent < 8 || sb.size() > 0); i++) begin
      stall = (i >= STAGES + 1) && (i < STAGES + 4);
      step(sent < 8, 16'h1000 + 16'(sent) * 16'h0111, 16'h0F0F ^ 16'(sent),
           2'(sent % 4), !stall, acc, dlv, rdy, ov, obs);
      checks++;
      if (rdy !== !stall) begin errors++; $display("FAIL b2b_in_ready cycle %0d got %b want %b", i, rdy, !stall); end
      if (acc) sent++;
      if (dlv) begin
        got++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_extra got %h want none", obs);
        end else begin
          ex = sb.pop_front();
          if (obs !== ex) begin errors++; $display("FAIL b2b_value beat %0d got %h want %h", got, obs, ex); end
        end
      end
    end
    checks++;
    if (got != 8 || sent != 8) begin errors++; $display("FAIL b2b_count got %0d/%0d want 8/8", got, sent); end
  endtask

  task automatic test_reset_midflight();
    logic acc, dlv, rdy, ov, got;
    out_t obs, ex;
    int   lat;
    for (int k = 0; k < 3; k++)
      step(1'b1, 16'h0100 + 16'(k), 16'h0003, 2'b00, 1'b0, acc, dlv, rdy, ov, obs);
    ov = out_valid;
    for (int c = 0; c < 2 * STAGES + 4 && !ov; c++)
      step(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, acc, dlv, rdy, ov, obs);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_fill out_valid got %b want 1", out_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async out_valid got %b want 0", out_valid); end
    checks++;
    if ({result, cout, z_out, v_out, n_out} !== 20'h0) begin
      errors++; $display("FAIL rst_async outputs got %h want 00000", {result, cout, z_out, v_out, n_out});
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2 * STAGES + 4; c++) begin
      step(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, acc, dlv, rdy, ov, obs);
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL rst_stale cycle %0d got out_valid %b want 0", c, ov); end
    end
    step(1'b1, 16'h1234, 16'h0234, 2'b01, 1'b1, acc, dlv, rdy, ov, obs);
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 3 * STAGES + 4 && !got; c++) begin
      step(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b1, acc, dlv, rdy, ov, obs);
      if (dlv) begin
        got = 1'b1;
        lat = c;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rst_next_value got %h want queued beat", obs);
        end else begin
          ex = sb.pop_front();
          if (obs !== ex) begin errors++; $display("FAIL rst_next_value got %h want %h", obs, ex); end
        end
      end
    end
    checks++;
    if (!got || lat != STAGES) begin
      errors++; $display("FAIL rst_next_latency got %0d want %0d (delivered=%b)", lat, STAGES, got);
    end
  endtask

  task automatic test_random();
    logic acc, dlv, rdy, ov, prev_stall, ordy;
    out_t obs, ex, prev;
    prev_stall = 1'b0;
    prev       = '0;
    for (int i = 0; i < 400 + 4 * STAGES + 40; i++) begin
      if (i >= 400 && sb.size() == 0 && !prev_stall) break;
      ordy = (i >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
      step((i < 400) && ($urandom_range(0, 3) != 0), pick(), pick(), 2'($urandom_range(0, 3)),
           ordy, acc, dlv, rdy, ov, obs);
      if (prev_stall) begin
        checks++;
        if (!ov || obs !== prev) begin
          errors++; $display("FAIL rand_hold cycle %0d got %h/%b want %h/1", i, obs, ov, prev);
        end
      end
      if (dlv) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_extra got %h want none", obs);
        end else begin
          ex = sb.pop_front();
          if (obs !== ex) begin errors++; $display("FAIL rand_value cycle %0d got %h want %h", i, obs, ex); end
        end
      end
      prev_stall = ov && !ordy;
      prev       = obs;
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rand_drain got %0d pending want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 4, number of pipeline stages (1..8); carry chain split into STAGES chunks of WIDTH/STAGES bits.
REQ-003 Ports SHALL be, one per line: name  direction  width  meaning.
  clk        in   1      single clock, all state on rising edge
  rst_n      in   1      reset, asynchronous, active-low
  in_valid   in   1      operand beat valid
  in_ready   out  1      block accepts a beat this cycle
  a          in   WIDTH  operand A
  b          in   WIDTH  operand B
  alufn      in   2      00 ADD, 01 SUB, 10 CMPEQ, 11 CMPLT (signed)
  out_valid  out  1      result beat valid
  out_ready  in   1      downstream accepts result
  result     out  WIDTH  sum/difference, or compare boolean in bit 0
  cout       out  1      carry out of MSB (SUB: 1 = no borrow)
  z_out      out  1      arithmetic result all zeros
  v_out      out  1      signed overflow
  n_out      out  1      arithmetic result MSB

Function
REQ-004 Operation SHALL be S = A + B' + cin, with B' = b, cin = 0 for ADD; B' = ~b, cin = 1 for SUB, CMPEQ, CMPLT.
REQ-005 Stage k (0-based) SHALL add chunk k of A and B' with carry from stage k-1 (stage 0: cin), register chunk result and carry; unprocessed operand chunks and finished result chunks SHALL travel with the beat.
REQ-006 Flags SHALL be computed on the full S in the last stage: z = (S == 0); n = S[WIDTH-1]; v = (A[MSB] == B'[MSB]) && (S[MSB] != A[MSB]); cout = final carry.
REQ-007 result SHALL be S for ADD/SUB; {0..0, z} for CMPEQ; {0..0, n ^ v} for CMPLT.
REQ-008 Flags and cout SHALL reflect S for every alufn, including compares.
REQ-009 Latency SHALL be exactly STAGES cycles from accepted input beat to out_valid with no stall; throughput one beat per cycle.
REQ-010 Beat accepted when in_valid && in_ready; delivered when out_valid && out_ready.
REQ-011 Global stall: advance = !out_valid || out_ready; in_ready = advance; all stages (valids and data) SHALL hold when advance = 0.
REQ-012 Per-stage valid bits SHALL propagate with data; bubbles (in_valid = 0 while advancing) SHALL propagate as invalid stages, and an invalid last stage SHALL not block advance.
REQ-013 While out_valid && !out_ready, result, flags and out_valid SHALL remain stable.
REQ-014 Simultaneous deliver and accept in the same cycle SHALL be lossless, no bubble inserted.
REQ-015 Outputs SHALL be registered (driven from last-stage flops); in_ready is the only combinational output (from out_valid, out_ready).
REQ-016 alufn SHALL be captured with the beat; changing alufn affects only newly accepted beats.

Reset
REQ-017 rst_n low SHALL asynchronously clear all stage valids, out_valid = 0, result = 0, cout = 0, z_out = 0, v_out = 0, n_out = 0.
REQ-018 Reset mid-operation SHALL discard all in-flight beats; no result delivered for them after release.
REQ-019 First rising clk edge with rst_n high SHALL accept a beat if in_valid (in_ready = 1 after reset).

Verification (WIDTH=16, STAGES=4)
REQ-020 ADD a=FFFF b=0001 -> after 4 cycles result=0000 cout=1 z=1 v=0 n=0.
REQ-021 SUB a=0101 b=0011 -> result=00F0 cout=1 z=0 v=0 n=0; SUB a=8000 b=0001 -> result=7FFF v=1 n=0 cout=1.
REQ-022 CMPLT a=C0FF b=EECC -> result=0001; CMPEQ a=A234 b=A234 -> result=0001 z=1; CMPEQ a=A234 b=8000 -> result=0000.
REQ-023 Back-to-back 8 beats, out_ready low for 3 cycles mid-stream -> in_ready low exactly those cycles, all 8 results in order, none lost or duplicated.
REQ-024 rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, no stale results after release, next beat result correct at latency 4.
REQ-025 Randomised ADD/SUB/compare with random in_valid/out_ready gaps against a reference model -> every field matches, also at STAGES=1 and STAGES=8.
